// File: rtl/rc4_ksa_engine.sv
// rc4_ksa_engine: RC4 key-scheduling engine (optional identity fill, then KSA swap loop)
// that shares the S-box RAM with other engines through a req/gnt handshake.
module rc4_ksa_engine #(
    parameter int ADDR_W    = 8,
    parameter int KEY_BYTES = 3,
    parameter bit INIT_EN   = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic [8*KEY_BYTES-1:0] secret_key,
    output logic                   busy,
    output logic                   done,
    output logic                   mem_req,
    input  logic                   mem_gnt,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [ADDR_W-1:0]      mem_wdata,
    output logic                   mem_wen,
    input  logic [ADDR_W-1:0]      mem_rdata
);
    localparam int KW = KEY_BYTES > 1 ? $clog2(KEY_BYTES) : 1;

    typedef enum logic [3:0] {IDLE, INIT_WR, RD_I, WAIT_I, RD_J, WAIT_J, WR_I, WR_J, DONE} state_t;

    state_t                 state;
    logic [8*KEY_BYTES-1:0] key_r;
    logic [ADDR_W-1:0]      i, j, temp_i, temp_j;
    logic [KW-1:0]          k;
    logic [7:0]             key_byte;
    logic                   stall;

    // RAM-facing outputs decode straight from state; only the write enable sees the grant.
    always_comb begin
        mem_req   = busy;
        mem_addr  = (state == RD_J || state == WR_J) ? j :
                    (state inside {INIT_WR, RD_I, WR_I}) ? i : '0;
        mem_wdata = (state == INIT_WR) ? i : (state == WR_I) ? temp_j : (state == WR_J) ? temp_i : '0;
        mem_wen   = mem_gnt && (state inside {INIT_WR, WR_I, WR_J});
        stall     = !mem_gnt && (state inside {INIT_WR, RD_I, RD_J, WR_I, WR_J});
        key_byte  = 8'(key_r >> (8 * (KEY_BYTES - 1 - int'(k))));
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state  <= IDLE;
            busy   <= 1'b0;
            done   <= 1'b0;
            key_r  <= '0;
            i      <= '0;
            j      <= '0;
            k      <= '0;
            temp_i <= '0;
            temp_j <= '0;
        end else begin
            done <= 1'b0;
            if (!stall) begin
                case (state)
                    IDLE: if (start) begin
                        key_r <= secret_key;
                        i     <= '0;
                        j     <= '0;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= INIT_EN ? INIT_WR : RD_I;
                    end
                    INIT_WR: begin
                        i     <= i + 1'b1;
                        state <= (i == '1) ? RD_I : INIT_WR;
                    end
                    RD_I: state <= WAIT_I;
                    WAIT_I: begin
                        temp_i <= mem_rdata;
                        j      <= j + mem_rdata + ADDR_W'(key_byte);
                        state  <= RD_J;
                    end
                    RD_J: state <= WAIT_J;
                    WAIT_J: begin
                        temp_j <= mem_rdata;
                        state  <= WR_I;
                    end
                    WR_I: state <= WR_J;
                    WR_J: if (i == '1) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        i     <= i + 1'b1;
                        k     <= (k == KW'(KEY_BYTES - 1)) ? '0 : k + KW'(1);
                        state <= RD_I;
                    end
                    DONE: state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_rc4_ksa_engine.sv
// tb_rc4_ksa_engine: three engine configurations on private RAM models, checked against
// a plain array-based RC4 KSA reference.
module tb_rc4_ksa_engine;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       gnt;
    logic [23:0] key;
    logic [2:0] start_v, busy_v, done_v, req_v, wen_v;
    logic [7:0] addr_v[3], wdata_v[3], rd_q[3];
    logic [7:0] ram[3][256];
    int         wr_cnt[3], bad_wen[3];
    logic       pre_we;
    int         pre_s, pre_a;
    logic [7:0] pre_d;
    logic [1:0] a_addr, a_wdata, a_rdata, b_addr, b_wdata, b_rdata;
    logic [7:0] c_addr, c_wdata, c_rdata;
    int         exp_s[256];
    int         n_checks = 0, n_errors = 0;

    always #5 clk = ~clk;

    rc4_ksa_engine #(.ADDR_W(2), .KEY_BYTES(2), .INIT_EN(1'b1)) u_a (
        .clk(clk), .reset_n(rst_n), .start(start_v[0]), .secret_key(key[15:0]),
        .busy(busy_v[0]), .done(done_v[0]), .mem_req(req_v[0]), .mem_gnt(gnt),
        .mem_addr(a_addr), .mem_wdata(a_wdata), .mem_wen(wen_v[0]), .mem_rdata(a_rdata));
    rc4_ksa_engine #(.ADDR_W(2), .KEY_BYTES(1), .INIT_EN(1'b0)) u_b (
        .clk(clk), .reset_n(rst_n), .start(start_v[1]), .secret_key(key[7:0]),
        .busy(busy_v[1]), .done(done_v[1]), .mem_req(req_v[1]), .mem_gnt(gnt),
        .mem_addr(b_addr), .mem_wdata(b_wdata), .mem_wen(wen_v[1]), .mem_rdata(b_rdata));
    rc4_ksa_engine #(.ADDR_W(8), .KEY_BYTES(3), .INIT_EN(1'b1)) u_c (
        .clk(clk), .reset_n(rst_n), .start(start_v[2]), .secret_key(key),
        .busy(busy_v[2]), .done(done_v[2]), .mem_req(req_v[2]), .mem_gnt(gnt),
        .mem_addr(c_addr), .mem_wdata(c_wdata), .mem_wen(wen_v[2]), .mem_rdata(c_rdata));

    always_comb begin
        addr_v[0]  = {6'b0, a_addr};
        wdata_v[0] = {6'b0, a_wdata};
        addr_v[1]  = {6'b0, b_addr};
        wdata_v[1] = {6'b0, b_wdata};
        addr_v[2]  = c_addr;
        wdata_v[2] = c_wdata;
    end
    assign a_rdata = rd_q[0][1:0];
    assign b_rdata = rd_q[1][1:0];
    assign c_rdata = rd_q[2];

    // synchronous RAMs, read data one cycle after the address; counters are free-running
    always @(posedge clk) begin
        for (int s = 0; s < 3; s++) begin
            if (wen_v[s]) begin
                ram[s][addr_v[s]] <= wdata_v[s];
                wr_cnt[s] <= wr_cnt[s] + 1;
            end
            if (wen_v[s] && !gnt) bad_wen[s] <= bad_wen[s] + 1;
            rd_q[s] <= ram[s][addr_v[s]];
        end
        if (pre_we) ram[pre_s][pre_a[7:0]] <= pre_d;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic model(input int n, input int kb, input logic [23:0] k, input bit init);
        int jj = 0;
        int t;
        if (init) for (int x = 0; x < n; x++) exp_s[x] = x;
        for (int x = 0; x < n; x++) begin
            jj = (jj + exp_s[x] + int'(k[8*(kb-1-x%kb) +: 8])) % n;
            t = exp_s[x];
            exp_s[x] = exp_s[jj];
            exp_s[jj] = t;
        end
    endtask

    task automatic preload(input int s, input int n, input bit rnd);
        for (int x = 0; x < n; x++) begin
            @(negedge clk);
            pre_we = 1'b1;
            pre_s  = s;
            pre_a  = x;
            pre_d  = rnd ? 8'($urandom_range(0, n - 1)) : 8'(x);
        end
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // mode 0: gnt high, 1: two 5-cycle gnt gaps, 2: random gnt; poke re-pulses start mid-run
    task automatic run(input int s, input int n, input int kb, input bit init, input logic [23:0] k,
                       input int mode, input int exp_cyc, input logic [31:0] exp_pack,
                       input int poke, input string tag);
        int cyc, bz = 0, w0, b0, bad = 0;
        if (!init) for (int x = 0; x < n; x++) exp_s[x] = int'(ram[s][x]);
        model(n, kb, k, init);
        w0 = wr_cnt[s];
        b0 = bad_wen[s];
        key = k;
        @(negedge clk);
        start_v[s] = 1'b1;
        @(negedge clk);
        start_v[s] = 1'b0;
        cyc = 1;
        while (cyc < 5000) begin
            gnt = mode == 0 ? 1'b1 :
                  mode == 1 ? !((cyc >= 7 && cyc < 12) || (cyc >= 20 && cyc < 25)) :
                  ($urandom_range(0, 3) != 0);
            if (cyc == poke) begin
                key = ~k;
                start_v[s] = 1'b1;
            end else start_v[s] = 1'b0;
            if (done_v[s]) break;
            bz += int'(busy_v[s]);
            @(negedge clk);
            cyc++;
        end
        gnt = 1'b1;
        start_v[s] = 1'b0;
        check({tag, "_done"}, done_v[s], 1);
        check({tag, "_busy_at_done"}, busy_v[s], 0);
        if (exp_cyc > 0) begin
            check({tag, "_done_cycle"}, cyc, exp_cyc);
            check({tag, "_busy_cycles"}, bz, exp_cyc - 1);
        end
        @(negedge clk);
        check({tag, "_done_pulse"}, done_v[s], 0);
        check({tag, "_writes"}, wr_cnt[s] - w0, (init ? n : 0) + 2 * n);
        check({tag, "_wen_no_gnt"}, bad_wen[s] - b0, 0);
        for (int x = 0; x < n; x++) if (int'(ram[s][x]) != exp_s[x]) bad++;
        check({tag, "_ram_mismatches"}, bad, 0);
        if (exp_pack != 32'hFFFF_FFFF)
            check({tag, "_ram"}, {ram[s][0], ram[s][1], ram[s][2], ram[s][3]}, exp_pack);
    endtask

    initial begin
        int seen;
        rst_n = 1'b0;
        gnt = 1'b1;
        key = '0;
        start_v = '0;
        pre_we = 1'b0;
        pre_s = 0;
        pre_a = 0;
        pre_d = '0;
        for (int s = 0; s < 3; s++) begin
            wr_cnt[s] = 0;
            bad_wen[s] = 0;
        end
        repeat (3) @(negedge clk);
        check("rst_busy", {29'b0, busy_v}, 0);
        check("rst_done", {29'b0, done_v}, 0);
        check("rst_req", {29'b0, req_v}, 0);
        check("rst_wen", {29'b0, wen_v}, 0);
        check("rst_addr", {a_addr, a_wdata, c_addr, c_wdata}, 0);
        rst_n = 1'b1;

        run(0, 4, 2, 1'b1, 24'h000101, 0, 29, 32'h00020301, 0, "s1");
        run(0, 4, 2, 1'b1, 24'h000301, 0, 29, 32'h03010200, 0, "s2_i_eq_j");
        run(0, 4, 2, 1'b1, 24'h000101, 1, 39, 32'h00020301, 0, "s3_stall");
        run(0, 4, 2, 1'b1, 24'h000301, 0, 29, 32'h03010200, 15, "start_ignored");

        preload(1, 4, 1'b0);
        run(1, 4, 1, 1'b0, 24'h000001, 0, 25, 32'h00020301, 0, "s4_noinit");
        for (int r = 0; r < 3; r++) begin
            preload(1, 4, 1'b1);
            run(1, 4, 1, 1'b0, 24'($urandom), 0, 25, 32'hFFFF_FFFF, 0, "rnd_noinit");
            run(0, 4, 2, 1'b1, 24'($urandom), 2, 0, 32'hFFFF_FFFF, 0, "rnd_gnt_small");
        end

        // asynchronous abort mid-run
        key = 24'h000301;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy_v[0], 0);
        check("abort_req", req_v[0], 0);
        check("abort_wen", wen_v[0], 0);
        check("abort_addr", {a_addr, a_wdata}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            seen |= int'(done_v[0]);
        end
        check("abort_no_done", seen, 0);
        run(0, 4, 2, 1'b1, 24'h000101, 0, 29, 32'h00020301, 0, "after_abort");

        run(2, 256, 3, 1'b1, 24'h000000, 0, 1793, 32'hFFFF_FFFF, 0, "s6_big");
        run(2, 256, 3, 1'b1, 24'($urandom), 2, 0, 32'hFFFF_FFFF, 100, "rnd_big");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
